simple_phase_seq: RTL and testbench

SIMPLE_PHASE_SEQ -- requirements
Module: simple_phase_seq

---
 rtl/simple_phase_seq.sv | 133 +++++++++++++
 tb/tb_simple_phase_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/simple_phase_seq.sv
// Multi-phase instruction sequencer: steps phase 0..NUM_PHASES-1 with a
// per-phase hold count, supports stall, flush and stop-after-instruction.
// Ports:
//   clk, reset (async, active-high)
//   start, stop, stall, flush, ph_len[LEN_W] : control inputs
//   phase[PH_W], phase_onehot[NUM_PHASES]    : current phase
//   phase_first, phase_last, instr_done      : phase/instruction status
//   instr_count[CNT_W], busy                 : retire count, RUN flag
module simple_phase_seq #(
  parameter int NUM_PHASES = 4,
  parameter int LEN_W      = 4,
  parameter int CNT_W      = 16,
  localparam int PH_W      = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [LEN_W-1:0]      ph_len,
  output logic [PH_W-1:0]       phase,
  output logic [NUM_PHASES-1:0] phase_onehot,
  output logic                  phase_first,
  output logic                  phase_last,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      instr_count,
  output logic                  busy
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(NUM_PHASES - 1);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [LEN_W-1:0]  hold_q, hold_d;
  logic              pend_q, pend_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          phase_d = '0;
          hold_d  = ph_len;
          first_d = 1'b1;
        end
      end
      RUN: begin
        if (flush) begin
          // A flush with a pending stop ends sequencing outright
          if (pend_q || stop) begin
            state_d = IDLE;
            phase_d = '0;
            hold_d  = '0;
            pend_d  = 1'b0;
          end else begin
            phase_d = '0;
            hold_d  = ph_len;
            first_d = 1'b1;
          end
        end else if (stall) begin
          pend_d = pend_q | stop;
        end else if (hold_q != '0) begin
          hold_d = hold_q - LEN_W'(1);
          pend_d = pend_q | stop;
        end else if (phase_q == PH_LAST) begin
          done  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (pend_q || stop) begin
            state_d = IDLE;
            phase_d = '0;
            hold_d  = '0;
            pend_d  = 1'b0;
          end else begin
            phase_d = '0;
            hold_d  = ph_len;
            first_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
          hold_d  = ph_len;
          first_d = 1'b1;
          pend_d  = pend_q | stop;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        hold_d  = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign phase        = phase_q;
  assign phase_first  = first_q;
  assign phase_last   = busy && (hold_q == '0);
  assign instr_done   = done;
  assign instr_count  = cnt_q;
  assign phase_onehot = busy ? (NUM_PHASES'(1) << phase_q) : '0;

endmodule

// File: tb/tb_simple_phase_seq.sv
// Scoreboard bench for simple_phase_seq, 4-phase and 5-phase instances.
// Expected outputs are queued per driven cycle and checked at negedge.
module tb_simple_phase_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [3:0] ph_len = '0;
  logic sel = 1'b0;

  logic [1:0]  ph4;
  logic [3:0]  oh4;
  logic        f4, l4, d4, b4;
  logic [15:0] c4;
  logic [2:0]  ph5;
  logic [4:0]  oh5;
  logic        f5, l5, d5, b5;
  logic [15:0] c5;

  simple_phase_seq #(.NUM_PHASES(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .stall(stall), .flush(flush), .ph_len(ph_len),
    .phase(ph4), .phase_onehot(oh4), .phase_first(f4),
    .phase_last(l4), .instr_done(d4), .instr_count(c4), .busy(b4)
  );

  simple_phase_seq #(.NUM_PHASES(5)) u_dut5 (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .stall(stall), .flush(flush), .ph_len(ph_len),
    .phase(ph5), .phase_onehot(oh5), .phase_first(f5),
    .phase_last(l5), .instr_done(d5), .instr_count(c5), .busy(b5)
  );

  always #5 clk = ~clk;

  logic [3:0]  o_ph;
  logic [15:0] o_oh;
  logic [3:0]  o_fl;
  logic [15:0] o_cnt;
  assign o_ph  = sel ? 4'(ph5) : 4'(ph4);
  assign o_oh  = sel ? 16'(oh5) : 16'(oh4);
  assign o_fl  = sel ? {b5, f5, l5, d5} : {b4, f4, l4, d4};
  assign o_cnt = sel ? c5 : c4;

  typedef struct {
    string       tag;
    logic [3:0]  ph;
    logic [3:0]  fl;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ctl = {start, stop, stall, flush}; efl = {busy, first, last, done}
  task automatic cyc(string tag, logic [3:0] ctl, logic [3:0] len,
                     logic [3:0] eph, logic [3:0] efl,
                     logic [15:0] ecnt);
    exp_t e;
    logic [15:0] eoh;
    @(posedge clk);
    #1;
    {start, stop, stall, flush} = ctl;
    ph_len = len;
    sb.push_back('{tag, eph, efl, ecnt});
    @(negedge clk);
    e = sb.pop_front();
    eoh = e.fl[3] ? (16'd1 << e.ph) : 16'd0;
    chk({e.tag, ":ph"}, 32'(o_ph), 32'(e.ph));
    chk({e.tag, ":fl"}, 32'(o_fl), 32'(e.fl));
    chk({e.tag, ":oh"}, 32'(o_oh), 32'(eoh));
    chk({e.tag, ":cnt"}, 32'(o_cnt), 32'(e.cnt));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ":ph"}, 32'(o_ph), 32'd0);
    chk({tag, ":fl"}, 32'(o_fl), 32'd0);
    chk({tag, ":oh"}, 32'(o_oh), 32'd0);
    chk({tag, ":cnt"}, 32'(o_cnt), 32'd0);
  endtask

  initial begin
    #2;
    chk_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    // back-to-back single-cycle phases
    cyc("a0", 4'b1000, 0, 0, 4'b0000, 0);
    cyc("a1", 4'b0000, 0, 0, 4'b1110, 0);
    cyc("a2", 4'b0000, 0, 1, 4'b1110, 0);
    cyc("a3", 4'b0000, 0, 2, 4'b1110, 0);
    cyc("a4", 4'b0000, 0, 3, 4'b1111, 0);
    cyc("a5", 4'b0000, 0, 0, 4'b1110, 1);
    // phase 2 held three cycles
    cyc("b0", 4'b0000, 2, 1, 4'b1110, 1);
    cyc("b1", 4'b0000, 0, 2, 4'b1100, 1);
    cyc("b2", 4'b0000, 0, 2, 4'b1000, 1);
    cyc("b3", 4'b0000, 0, 2, 4'b1010, 1);
    cyc("b4", 4'b0000, 0, 3, 4'b1111, 1);
    cyc("b5", 4'b0000, 1, 0, 4'b1110, 2);
    // five stalled cycles in phase 1 with hold=1
    cyc("c0", 4'b0010, 0, 1, 4'b1100, 2);
    cyc("c1", 4'b0010, 0, 1, 4'b1000, 2);
    cyc("c2", 4'b0010, 0, 1, 4'b1000, 2);
    cyc("c3", 4'b0010, 0, 1, 4'b1000, 2);
    cyc("c4", 4'b0010, 0, 1, 4'b1000, 2);
    cyc("c5", 4'b0000, 0, 1, 4'b1000, 2);
    cyc("c6", 4'b0000, 0, 1, 4'b1010, 2);
    cyc("c7", 4'b0000, 0, 2, 4'b1110, 2);
    cyc("c8", 4'b0000, 0, 3, 4'b1111, 2);
    // flush wins over stall
    cyc("d0", 4'b0000, 0, 0, 4'b1110, 3);
    cyc("d1", 4'b0000, 0, 1, 4'b1110, 3);
    cyc("d2", 4'b0011, 0, 2, 4'b1110, 3);
    cyc("d3", 4'b0000, 0, 0, 4'b1110, 3);
    // stop completes the instruction then idles
    cyc("e0", 4'b0100, 0, 1, 4'b1110, 3);
    cyc("e1", 4'b0000, 0, 2, 4'b1110, 3);
    cyc("e2", 4'b0000, 0, 3, 4'b1111, 3);
    cyc("e3", 4'b0100, 0, 0, 4'b0000, 4);
    cyc("e4", 4'b1000, 0, 0, 4'b0000, 4);
    cyc("e5", 4'b1000, 0, 0, 4'b1110, 4);
    cyc("e6", 4'b0000, 0, 1, 4'b1110, 4);
    cyc("e7", 4'b0000, 0, 2, 4'b1110, 4);
    cyc("e8", 4'b0000, 0, 3, 4'b1111, 4);
    cyc("e9", 4'b0100, 0, 0, 4'b1110, 5);
    cyc("e10", 4'b0001, 0, 1, 4'b1110, 5);
    cyc("e11", 4'b0001, 0, 0, 4'b0000, 5);
    cyc("e12", 4'b0000, 0, 0, 4'b0000, 5);

    // five-phase instance
    @(negedge clk);
    reset = 1'b1;
    sel = 1'b1;
    #1;
    chk_zero("rst5");
    @(negedge clk);
    reset = 1'b0;
    cyc("f0", 4'b1000, 0, 0, 4'b0000, 0);
    cyc("f1", 4'b0000, 0, 0, 4'b1110, 0);
    cyc("f2", 4'b0000, 0, 1, 4'b1110, 0);
    cyc("f3", 4'b0000, 0, 2, 4'b1110, 0);
    cyc("f4", 4'b0000, 0, 3, 4'b1110, 0);
    cyc("f5", 4'b0000, 0, 4, 4'b1111, 0);
    cyc("f6", 4'b0000, 0, 0, 4'b1110, 1);
    cyc("f7", 4'b0000, 0, 1, 4'b1110, 1);
    cyc("f8", 4'b0000, 2, 2, 4'b1110, 1);
    cyc("f9", 4'b0000, 0, 3, 4'b1100, 1);
    cyc("f10", 4'b0000, 0, 3, 4'b1000, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("arst");
    @(negedge clk);
    chk_zero("arst_hold");
    reset = 1'b0;
    cyc("g0", 4'b0000, 0, 0, 4'b0000, 0);
    cyc("g1", 4'b0000, 0, 0, 4'b0000, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
